i2c_master: RTL and testbench

Single-register I2C bus master that runs on the system clock and generates the opposite end of our `i2c_slave` protocol. Each transaction is one of two fixed sequences:
- Write: START, address+W, register index, data, STOP.
- Read: START, address+W, register index, repeated START, address+R, one data byte (master NACKs), STOP.

The block sits between a host register interface and the open-drain SCL/SDA pins. It handles slave clock stretching and reports a slave NACK.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_qtick.sv | 23 ++
 rtl/i2c_master.sv | 165 ++++++++++++++++
 tb/tb_i2c_master.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C master/slave definitions: FSM states, quarter phases, slot count, default address.
package i2c_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_STA, S_ADDR_W, S_IDX, S_WR_DATA, S_RSTA, S_ADDR_R, S_RD_DATA, S_STO, S_BUS_FREE
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [3:0] BIT_SLOTS        = 4'd9;
    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h27;

    function automatic logic is_tx_byte(state_e s);
        return s == S_ADDR_W || s == S_IDX || s == S_WR_DATA || s == S_ADDR_R;
    endfunction

    function automatic logic is_byte(state_e s);
        return is_tx_byte(s) || s == S_RD_DATA;
    endfunction
endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: quarter-SCL-period tick; the final count stalls while hold_i is high (clock stretching).
module i2c_qtick #(
    parameter int CLK_DIV = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic hold_i,
    output logic tick_o
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && cnt_q == LAST && !hold_i;
    assign cnt_d  = (!en_i || tick_o) ? '0 : (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-register I2C master (write: S,AW,IDX,D,P; read: S,AW,IDX,Sr,AR,D+NACK,P)
// with slave clock stretching and NACK abort. SCL/SDA are open drain.
module i2c_master #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [6:0] dev_addr_i,
    input  logic [7:0] reg_idx_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_err_o,
    output logic [7:0] rdata_o,
    inout  wire        scl_io,
    inout  wire        sda_io
);
    import i2c_pkg::*;

    state_e     state_q, state_d;
    logic [1:0] scl_sync_q, sda_sync_q, qph_q, qph_d;
    logic [3:0] bit_q, bit_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] idx_q, idx_d, wd_q, wd_d, rx_q, rx_d, rdata_q, rdata_d, tx_byte;
    logic       rw_q, rw_d, samp_q, samp_d, busy_q, busy_d, go_q, done_q, done_d, nack_q, nack_d;
    logic       scl_low_q, scl_low_d, sda_low_q, sda_low_d;
    logic       tick, hold, last_slot;

    // Stretch detect only while SCL is released by us; sync lag is absorbed since CLK_DIV >= 4.
    assign hold      = qph_q == Q2 && !scl_low_q && !scl_sync_q[1];
    assign last_slot = bit_q == BIT_SLOTS - 4'd1;

    // go_q delays the divider one cycle after accept.
    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (busy_q && go_q),
        .hold_i(hold),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        qph_d   = qph_q;
        bit_d   = bit_q;
        dev_d   = dev_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        rw_d    = rw_q;
        rx_d    = rx_q;
        samp_d  = samp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        nack_d  = nack_q;
        rdata_d = rdata_q;
        if (state_q == S_IDLE) begin
            if (start_i) begin
                state_d = S_STA;
                qph_d   = Q0;
                bit_d   = '0;
                dev_d   = dev_addr_i;
                idx_d   = reg_idx_i;
                wd_d    = wdata_i;
                rw_d    = rw_i;
                busy_d  = 1'b1;
                nack_d  = 1'b0;
            end
        end else if (tick) begin
            qph_d = qph_q + 2'd1;
            if (qph_q == Q2) begin
                samp_d = sda_sync_q[1];
                if (state_q == S_RD_DATA && !last_slot) rx_d = {rx_q[6:0], sda_sync_q[1]};
            end
            if (qph_q == Q3) begin
                unique case (state_q)
                    S_STA:      state_d = S_ADDR_W;
                    S_RSTA:     state_d = S_ADDR_R;
                    S_STO:      state_d = S_BUS_FREE;
                    S_BUS_FREE: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: begin
                        bit_d = last_slot ? 4'd0 : bit_q + 4'd1;
                        if (last_slot && state_q == S_RD_DATA) begin
                            rdata_d = rx_q;
                            state_d = S_STO;
                        end else if (last_slot && samp_q) begin
                            nack_d  = 1'b1;
                            state_d = S_STO;
                        end else if (last_slot) begin
                            state_d = state_q == S_ADDR_W ? S_IDX :
                                      state_q == S_IDX    ? (rw_q ? S_RSTA : S_WR_DATA) :
                                      state_q == S_ADDR_R ? S_RD_DATA : S_STO;
                        end
                    end
                endcase
            end
        end
    end

    // Line drive derived from next state so the pins come straight from flops.
    always_comb begin
        tx_byte   = state_d == S_ADDR_W  ? {dev_q, 1'b0} :
                    state_d == S_IDX     ? idx_q :
                    state_d == S_WR_DATA ? wd_q : {dev_q, 1'b1};
        scl_low_d = (is_byte(state_d) && qph_d inside {Q0, Q1}) ||
                    ((state_d == S_RSTA || state_d == S_STO) && qph_d == Q0);
        sda_low_d = ((state_d == S_STA || state_d == S_RSTA) && qph_d inside {Q2, Q3}) ||
                    (state_d == S_STO && qph_d inside {Q0, Q1}) ||
                    (is_tx_byte(state_d) && bit_d != BIT_SLOTS - 4'd1 && !tx_byte[3'd7 - bit_d[2:0]]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            qph_q      <= Q0;
            bit_q      <= '0;
            dev_q      <= '0;
            idx_q      <= '0;
            wd_q       <= '0;
            rw_q       <= 1'b0;
            rx_q       <= '0;
            samp_q     <= 1'b0;
            busy_q     <= 1'b0;
            go_q       <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            rdata_q    <= '0;
            scl_low_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            qph_q      <= qph_d;
            bit_q      <= bit_d;
            dev_q      <= dev_d;
            idx_q      <= idx_d;
            wd_q       <= wd_d;
            rw_q       <= rw_d;
            rx_q       <= rx_d;
            samp_q     <= samp_d;
            busy_q     <= busy_d;
            go_q       <= busy_q;
            done_q     <= done_d;
            nack_q     <= nack_d;
            rdata_q    <= rdata_d;
            scl_low_q  <= scl_low_d;
            sda_low_q  <= sda_low_d;
            scl_sync_q <= {scl_sync_q[0], scl_io};
            sda_sync_q <= {sda_sync_q[0], sda_io};
        end
    end

    assign scl_io     = scl_low_q ? 1'b0 : 1'bz;
    assign sda_io     = sda_low_q ? 1'b0 : 1'bz;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign nack_err_o = nack_q;
    assign rdata_o    = rdata_q;
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master against a behavioural register slave at DEV_ADDR_DEFAULT.
module tb_i2c_master;
    import i2c_pkg::*;

    localparam int D      = 4;
    localparam int WR_CYC = 1 + 120 * D;
    localparam int RD_CYC = 1 + 160 * D;
    localparam int NK_CYC = 1 + 48 * D;

    logic       clk = 1'b0;
    logic       rst_n, start, rw;
    logic [6:0] dev;
    logic [7:0] idx, wd, rdata;
    logic       busy, done, nack;
    logic       tb_scl_low, slv_sda_low, slv_rst;
    wire        scl_w, sda_w;

    int checks = 0;
    int errors = 0;

    pullup (scl_w);
    pullup (sda_w);
    assign scl_w = tb_scl_low  ? 1'b0 : 1'bz;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master #(.CLK_DIV(D)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .rw_i      (rw),
        .dev_addr_i(dev),
        .reg_idx_i (idx),
        .wdata_i   (wd),
        .busy_o    (busy),
        .done_o    (done),
        .nack_err_o(nack),
        .rdata_o   (rdata),
        .scl_io    (scl_w),
        .sda_io    (sda_w)
    );

    // Behavioural slave: samples the bus on clk, 16 registers, auto-increment pointer.
    logic       ps, pd, active, tx, srw, mack;
    logic [7:0] shift, ptr;
    logic [7:0] regs [16];
    int         cnt, bytenum, falls, starts;

    always @(posedge clk) begin
        ps <= scl_w;
        pd <= sda_w;
        if (slv_rst) begin
            ps <= 1'b1; pd <= 1'b1; active <= 1'b0; tx <= 1'b0; srw <= 1'b0; mack <= 1'b0;
            slv_sda_low <= 1'b0; cnt <= 0; bytenum <= 0; falls <= 0; starts <= 0; ptr <= '0; shift <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else if (ps && scl_w && pd && !sda_w) begin
            active <= 1'b1; cnt <= 0; bytenum <= 0; tx <= 1'b0; slv_sda_low <= 1'b0;
            falls <= 0; starts <= starts + 1;
        end else if (ps && scl_w && !pd && sda_w) begin
            active <= 1'b0; slv_sda_low <= 1'b0;
        end else if (!ps && scl_w && active) begin
            cnt <= cnt + 1;
            if (!tx && cnt < 8) shift <= {shift[6:0], sda_w};
            if (tx && cnt == 8) mack <= sda_w;
        end else if (ps && !scl_w) begin
            falls <= falls + 1;
            if (active) begin
                if (cnt == 8 && !tx) begin
                    if (bytenum == 0) begin
                        if (shift[7:1] == DEV_ADDR_DEFAULT) begin slv_sda_low <= 1'b1; srw <= shift[0]; end
                        else active <= 1'b0;
                    end else begin
                        slv_sda_low <= 1'b1;
                        if (bytenum == 1) ptr <= shift;
                        else begin regs[ptr[3:0]] <= shift; ptr <= ptr + 8'd1; end
                    end
                end else if (cnt == 8) begin
                    slv_sda_low <= 1'b0;
                end else if (cnt == 9) begin
                    cnt <= 0;
                    bytenum <= bytenum + 1;
                    tx <= tx || (srw && bytenum == 0);
                    slv_sda_low <= srw && bytenum == 0 && !tx && !regs[ptr[3:0]][7];
                end else if (tx && cnt >= 1 && cnt <= 7) begin
                    slv_sda_low <= !regs[ptr[3:0]][3'(7 - cnt)];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic r, input logic [6:0] a, input logic [7:0] i, input logic [7:0] w);
        @(negedge clk);
        rw = r; dev = a; idx = i; wd = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        check("nack_cleared", nack, 1'b0);
    endtask

    task automatic xfer(input logic r, input logic [6:0] a, input logic [7:0] i, input logic [7:0] w,
                        output int n);
        kick(r, a, i, w);
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
    endtask

    task automatic wait_falls(input int f);
        int k = 0;
        while (falls != f && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("scl_fall_reached", falls, f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, s0;
        rst_n = 1'b0; slv_rst = 1'b1; start = 1'b0; rw = 1'b0; dev = '0; idx = '0; wd = '0; tb_scl_low = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_nack", nack, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_scl", scl_w, 1'b1);
        check("rst_sda", sda_w, 1'b1);
        rst_n = 1'b1; slv_rst = 1'b0;
        repeat (3) @(negedge clk);

        s0 = starts;
        xfer(1'b0, 7'h27, 8'h03, 8'h57, n);
        check("wr_latency", n, WR_CYC);
        check("wr_reg03", regs[3], 8'h57);
        check("wr_nack", nack, 1'b0);
        check("wr_starts", starts - s0, 1);

        s0 = starts;
        xfer(1'b1, 7'h27, 8'h03, 8'h00, n);
        check("rd_latency", n, RD_CYC);
        check("rd_rdata", rdata, 8'h57);
        check("rd_nack", nack, 1'b0);
        check("rd_repeated_start", starts - s0, 2);
        check("rd_master_nack", mack, 1'b1);

        xfer(1'b0, 7'h28, 8'h03, 8'h11, n);
        check("na_latency", n, NK_CYC);
        check("na_nack", nack, 1'b1);
        check("na_reg03", regs[3], 8'h57);
        check("na_rdata_kept", rdata, 8'h57);

        fork
            xfer(1'b0, 7'h27, 8'h05, 8'h3C, n);
            begin
                wait_falls(13);
                tb_scl_low = 1'b1;
                repeat (2 * D + 55) @(negedge clk);
                tb_scl_low = 1'b0;
            end
        join
        check("st_delay_ge_50", n >= WR_CYC + 50, 1'b1);
        check("st_reg05", regs[5], 8'h3C);
        check("st_nack", nack, 1'b0);

        s0 = starts;
        fork
            xfer(1'b0, 7'h27, 8'h06, 8'hC3, n);
            begin
                repeat (100) @(negedge clk);
                rw = 1'b0; dev = 7'h27; idx = 8'h01; wd = 8'h99; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check("sb_latency", n, WR_CYC);
        check("sb_reg06", regs[6], 8'hC3);
        check("sb_reg01", regs[1], 8'h00);
        check("sb_starts", starts - s0, 1);
        repeat (20) @(negedge clk);
        check("sb_idle_after", busy, 1'b0);

        kick(1'b0, 7'h27, 8'h02, 8'h11);
        wait_falls(23);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_scl_released", scl_w, 1'b1);
        check("mr_sda_released", sda_w, 1'b1);
        check("mr_busy", busy, 1'b0);
        check("mr_done", done, 1'b0);
        check("mr_nack", nack, 1'b0);
        check("mr_rdata", rdata, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        xfer(1'b0, 7'h27, 8'h00, 8'hA5, n);
        check("mr_wr_latency", n, WR_CYC);
        check("mr_reg00", regs[0], 8'hA5);
        check("mr_reg02_untouched", regs[2], 8'h00);
        check("mr_nack_after", nack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
